ioctl_tx: RTL and testbench

IOCTL_TX -- requirements
Module: ioctl_tx

---
 rtl/ioctl_tx.sv | 146 ++++++++++++++
 tb/tb_ioctl_tx.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ioctl_tx.sv
// ioctl_tx: streams a source byte sequence into an ioctl download sink.
// Ports: clk_sys/reset_n; start/index/length/abort control; src_* byte
// source (valid/ready); ioctl_wait sink back-pressure; ioctl_download,
// ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout sink side; busy, done.
module ioctl_tx #(
    parameter int GAP = 3,
    parameter int AW  = 25
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          start,
    input  logic [7:0]    index,
    input  logic [AW-1:0] length,
    input  logic          abort,
    input  logic [7:0]    src_data,
    input  logic          src_valid,
    output logic          src_ready,
    input  logic          ioctl_wait,
    output logic          ioctl_download,
    output logic [7:0]    ioctl_index,
    output logic          ioctl_wr,
    output logic [AW-1:0] ioctl_addr,
    output logic [7:0]    ioctl_dout,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_SEND,
        S_GAP,
        S_FINISH
    } state_t;

    // The GAP state covers the strobe cycle itself, so a mid-stream byte
    // needs GAP-1 more cycles to give one write per GAP+1 cycles. After the
    // last byte the full GAP cycles follow the strobe before FINISH.
    localparam logic [3:0] GAP_MID  = (GAP == 0) ? 4'd0 : 4'(GAP - 1);
    localparam logic [3:0] GAP_LAST = 4'(GAP);

    state_t        state;
    logic [AW-1:0] len;
    logic [AW-1:0] cnt;
    logic [AW-1:0] cnt_inc;
    logic [3:0]    gcnt;
    logic          send_q;
    logic          hs;
    logic          last;
    logic [1:0]    rst_sync;
    logic          rst_n_s;

    // Assert asynchronously, release two edges later.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) rst_sync <= 2'b00;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_n_s   = rst_sync[1];
    assign src_ready = send_q & ~ioctl_wait & ~abort;
    assign hs        = src_ready & src_valid;
    assign cnt_inc   = cnt + 1'b1;
    assign last      = (cnt_inc == len);

    always_ff @(posedge clk_sys or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state          <= S_IDLE;
            len            <= '0;
            cnt            <= '0;
            gcnt           <= '0;
            send_q         <= 1'b0;
            ioctl_download <= 1'b0;
            ioctl_index    <= '0;
            ioctl_wr       <= 1'b0;
            ioctl_addr     <= '0;
            ioctl_dout     <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            ioctl_wr <= 1'b0;
            done     <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start && length != '0) begin
                        ioctl_index    <= index;
                        len            <= length;
                        cnt            <= '0;
                        ioctl_download <= 1'b1;
                        busy           <= 1'b1;
                        state          <= S_START;
                    end
                end
                S_START: begin
                    if (abort) begin
                        ioctl_download <= 1'b0;
                        done           <= 1'b1;
                        state          <= S_FINISH;
                    end else begin
                        send_q <= 1'b1;
                        state  <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (abort) begin
                        send_q         <= 1'b0;
                        ioctl_download <= 1'b0;
                        done           <= 1'b1;
                        state          <= S_FINISH;
                    end else if (hs) begin
                        ioctl_wr   <= 1'b1;
                        ioctl_dout <= src_data;
                        ioctl_addr <= cnt;
                        cnt        <= cnt_inc;
                        if (last) begin
                            send_q <= 1'b0;
                            gcnt   <= GAP_LAST;
                            state  <= S_GAP;
                        end else if (GAP != 0) begin
                            send_q <= 1'b0;
                            gcnt   <= GAP_MID;
                            state  <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (abort || (gcnt == 4'd0 && cnt == len)) begin
                        ioctl_download <= 1'b0;
                        done           <= 1'b1;
                        state          <= S_FINISH;
                    end else if (gcnt == 4'd0) begin
                        send_q <= 1'b1;
                        state  <= S_SEND;
                    end else begin
                        gcnt <= gcnt - 4'd1;
                    end
                end
                S_FINISH: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ioctl_tx.sv
// tb_ioctl_tx: scoreboard bench for ioctl_tx (GAP=3 instance plus a
// GAP=0 instance for back-to-back writes).
module tb_ioctl_tx;

    localparam int G = 3;

    typedef struct packed {
        logic [24:0] a;
        logic [7:0]  d;
    } wr_t;

    logic        clk_sys;
    logic        reset_n;
    logic        start;
    logic [7:0]  index;
    logic [24:0] length;
    logic        abort;
    logic [7:0]  src_data;
    logic        src_valid;
    logic        src_ready;
    logic        ioctl_wait;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        busy;
    logic        done;

    logic        z_start;
    logic [24:0] z_length;
    logic [7:0]  z_src_data;
    logic        z_src_ready;
    logic        z_download;
    logic [7:0]  z_index;
    logic        z_wr;
    logic [24:0] z_addr;
    logic [7:0]  z_dout;
    logic        z_busy;
    logic        z_done;
    logic [7:0]  z_hs;

    int checks;
    int failures;
    int cyc;
    int n_wr;
    int n_done;
    int hs_count;
    int valid_pct;
    int t_acc;
    int done_cyc;
    int z_done_cyc;
    bit hs_pend;
    logic [7:0] exp_idx;

    wr_t         exp_q[$];
    int          exp_done_q[$];
    logic [7:0]  src_q[$];
    int          wr_cyc[$];
    int          zq_cyc[$];
    logic [24:0] zq_a[$];
    logic [7:0]  zq_d[$];

    ioctl_tx #(.GAP(G), .AW(25)) dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .start          (start),
        .index          (index),
        .length         (length),
        .abort          (abort),
        .src_data       (src_data),
        .src_valid      (src_valid),
        .src_ready      (src_ready),
        .ioctl_wait     (ioctl_wait),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .busy           (busy),
        .done           (done)
    );

    ioctl_tx #(.GAP(0), .AW(25)) dut0 (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .start          (z_start),
        .index          (8'h07),
        .length         (z_length),
        .abort          (1'b0),
        .src_data       (z_src_data),
        .src_valid      (1'b1),
        .src_ready      (z_src_ready),
        .ioctl_wait     (1'b0),
        .ioctl_download (z_download),
        .ioctl_index    (z_index),
        .ioctl_wr       (z_wr),
        .ioctl_addr     (z_addr),
        .ioctl_dout     (z_dout),
        .busy           (z_busy),
        .done           (z_done)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    initial cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    initial z_hs = 8'd0;
    always @(posedge clk_sys)
        if (z_src_ready) z_hs <= z_hs + 8'd1;
    assign z_src_data = 8'h30 + z_hs;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic unexpected(input string nm);
        checks++;
        failures++;
        $display("FAIL %s actual=event required=none", nm);
    endtask

    // Source model: presents queued bytes in order, pops on handshake.
    initial begin
        src_valid = 1'b0;
        src_data  = 8'h00;
        hs_pend   = 1'b0;
        forever begin
            @(negedge clk_sys);
            if (hs_pend) begin
                void'(src_q.pop_front());
                hs_count++;
            end
            if (src_q.size() > 0 && $urandom_range(99) < valid_pct) begin
                src_valid = 1'b1;
                src_data  = src_q[0];
            end else begin
                src_valid = 1'b0;
                src_data  = 8'($urandom);
            end
            #3 hs_pend = src_valid && src_ready;
        end
    end

    // Monitor: pops the scoreboard on every write strobe and done pulse.
    always @(negedge clk_sys) begin
        if (ioctl_wr) begin
            wr_t e;
            wr_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                unexpected("wr_unexpected");
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(ioctl_addr), 32'(e.a));
                chk("wr_dout", 32'(ioctl_dout), 32'(e.d));
            end
            chk("wr_download", 32'(ioctl_download), 32'd1);
            chk("wr_index", 32'(ioctl_index), 32'(exp_idx));
            n_wr++;
        end
        if (done) begin
            done_cyc = cyc;
            n_done++;
            if (exp_done_q.size() == 0) begin
                unexpected("done_unexpected");
            end else begin
                chk("done_count", 32'(n_wr), 32'(exp_done_q.pop_front()));
            end
            chk("done_download", 32'(ioctl_download), 32'd0);
            n_wr = 0;
        end
    end

    always @(negedge clk_sys) begin
        if (z_wr) begin
            zq_cyc.push_back(cyc);
            zq_a.push_back(z_addr);
            zq_d.push_back(z_dout);
        end
        if (z_done) z_done_cyc = cyc;
    end

    task automatic xfer(input logic [7:0] idx, input int len,
                        input int nexp, input bit has_done, input bit fixed);
        for (int k = 0; k < len; k++) begin
            logic [7:0] b;
            b = fixed ? 8'(8'hA0 + k) : 8'($urandom);
            src_q.push_back(b);
            if (k < nexp) exp_q.push_back({25'(k), b});
        end
        if (has_done) exp_done_q.push_back(nexp);
        exp_idx  = idx;
        hs_count = 0;
        @(negedge clk_sys);
        start  = 1'b1;
        index  = idx;
        length = 25'(len);
        @(negedge clk_sys);
        start = 1'b0;
        t_acc = cyc;
    endtask

    task automatic wait_hs(input int n);
        int i;
        for (i = 0; i < 300 && hs_count < n; i++) begin
            @(negedge clk_sys);
            #1;
        end
        chk("hs_reached", 32'(hs_count >= n), 32'd1);
    endtask

    task automatic wait_done(input int budget, input bit rnd);
        int d0;
        d0 = n_done;
        for (int i = 0; i < budget && n_done == d0; i++) begin
            @(negedge clk_sys);
            #1;
            if (rnd) ioctl_wait = ($urandom_range(9) < 2);
        end
        ioctl_wait = 1'b0;
        chk("done_seen", 32'(n_done - d0), 32'd1);
        @(negedge clk_sys);
        #1;
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_download", 32'(ioctl_download), 32'd0);
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_download"}, 32'(ioctl_download), 32'd0);
        chk({pfx, "_wr"}, 32'(ioctl_wr), 32'd0);
        chk({pfx, "_addr"}, 32'(ioctl_addr), 32'd0);
        chk({pfx, "_dout"}, 32'(ioctl_dout), 32'd0);
        chk({pfx, "_index"}, 32'(ioctl_index), 32'd0);
        chk({pfx, "_busy"}, 32'(busy), 32'd0);
        chk({pfx, "_done"}, 32'(done), 32'd0);
        chk({pfx, "_src_ready"}, 32'(src_ready), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int d0;
        int len;
        checks     = 0;
        failures   = 0;
        n_wr       = 0;
        n_done     = 0;
        hs_count   = 0;
        done_cyc   = -1;
        z_done_cyc = -1;
        exp_idx    = 8'h00;
        valid_pct  = 100;
        reset_n    = 1'b0;
        start      = 1'b0;
        index      = 8'h00;
        length     = '0;
        abort      = 1'b0;
        ioctl_wait = 1'b0;
        z_start    = 1'b0;
        z_length   = '0;

        repeat (3) @(negedge clk_sys);
        #1;
        chk_zero("reset");

        // A start on the first edge after release must be ignored.
        @(negedge clk_sys);
        reset_n = 1'b1;
        start   = 1'b1;
        index   = 8'h66;
        length  = 25'd2;
        @(negedge clk_sys);
        start = 1'b0;
        repeat (4) begin
            #1 chk("early_start_busy", 32'(busy), 32'd0);
            @(negedge clk_sys);
        end

        // Free-flowing 4-byte transfer: timing against GAP.
        wr_cyc.delete();
        done_cyc = -1;
        xfer(8'h05, 4, 4, 1'b1, 1'b1);
        #1;
        chk("start_wr", 32'(ioctl_wr), 32'd0);
        chk("start_index", 32'(ioctl_index), 32'h05);
        chk("start_src_ready", 32'(src_ready), 32'd0);
        for (int t = 0; t < 20; t++) begin
            chk("a_download", 32'(ioctl_download), 32'(t <= 2 + 3 * (G + 1) + G));
            chk("a_busy", 32'(busy), 32'(t <= 3 + 3 * (G + 1) + G));
            @(negedge clk_sys);
            #1;
        end
        chk("a_wr_count", 32'(wr_cyc.size()), 32'd4);
        for (int k = 0; k < 4; k++)
            if (k < wr_cyc.size())
                chk("a_wr_cycle", 32'(wr_cyc[k] - t_acc), 32'(2 + k * (G + 1)));
        chk("a_done_cycle", 32'(done_cyc - t_acc), 32'(2 + 3 * (G + 1) + G + 1));

        // GAP=0 instance: three writes on consecutive cycles.
        @(negedge clk_sys);
        z_start  = 1'b1;
        z_length = 25'd3;
        @(negedge clk_sys);
        z_start = 1'b0;
        t_acc   = cyc;
        #1;
        chk("z_start_src_ready", 32'(z_src_ready), 32'd0);
        chk("z_start_download", 32'(z_download), 32'd1);
        chk("z_start_index", 32'(z_index), 32'h07);
        repeat (8) @(negedge clk_sys);
        #1;
        chk("z_wr_count", 32'(zq_cyc.size()), 32'd3);
        for (int k = 0; k < 3; k++) begin
            if (k < zq_cyc.size()) begin
                chk("z_wr_cycle", 32'(zq_cyc[k] - t_acc), 32'(2 + k));
                chk("z_wr_addr", 32'(zq_a[k]), 32'(k));
                chk("z_wr_dout", 32'(zq_d[k]), 32'(8'h30 + k));
            end
        end
        chk("z_done_cycle", 32'(z_done_cyc - t_acc), 32'd5);
        chk("z_idle", 32'(z_busy), 32'd0);

        // Sink back-pressure held for 10 cycles mid-stream.
        xfer(8'h3C, 6, 6, 1'b1, 1'b0);
        wait_hs(2);
        ioctl_wait = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("wait_src_ready", 32'(src_ready), 32'd0);
            if (i > 0) chk("wait_wr", 32'(ioctl_wr), 32'd0);
            @(negedge clk_sys);
            #1;
        end
        ioctl_wait = 1'b0;
        wait_done(300, 1'b0);

        // Abort right after the second handshake of an 8-byte transfer.
        xfer(8'h22, 8, 2, 1'b1, 1'b0);
        wait_hs(2);
        abort = 1'b1;
        @(negedge clk_sys);
        abort = 1'b0;
        wait_done(100, 1'b0);
        src_q.delete();

        // Zero length start does nothing.
        d0 = n_done;
        @(negedge clk_sys);
        start  = 1'b1;
        index  = 8'h77;
        length = '0;
        @(negedge clk_sys);
        start = 1'b0;
        repeat (5) begin
            #1;
            chk("len0_busy", 32'(busy), 32'd0);
            chk("len0_download", 32'(ioctl_download), 32'd0);
            @(negedge clk_sys);
        end
        chk("len0_no_done", 32'(n_done - d0), 32'd0);

        // Start while busy is ignored.
        xfer(8'h11, 5, 5, 1'b1, 1'b0);
        wait_hs(1);
        start  = 1'b1;
        index  = 8'h99;
        length = 25'd2;
        @(negedge clk_sys);
        start = 1'b0;
        #1;
        chk("busy_start_index", 32'(ioctl_index), 32'h11);
        wait_done(300, 1'b0);

        // Randomized transfers with random source stalls and back-pressure.
        valid_pct = 60;
        for (int r = 0; r < 8; r++) begin
            len = $urandom_range(1, 8);
            xfer(8'($urandom), len, len, 1'b1, 1'b0);
            wait_done(600, 1'b1);
        end

        // Reset during the gap of byte 5.
        valid_pct = 100;
        xfer(8'h5A, 8, 5, 1'b0, 1'b0);
        wait_hs(5);
        d0 = n_done;
        reset_n = 1'b0;
        #1;
        chk_zero("midrst");
        chk("midrst_pending_wr", 32'(exp_q.size()), 32'd0);
        src_q.delete();
        n_wr = 0;
        repeat (2) @(negedge clk_sys);
        reset_n = 1'b1;
        repeat (4) @(negedge clk_sys);
        chk("midrst_no_done", 32'(n_done - d0), 32'd0);
        xfer(8'h5B, 3, 3, 1'b1, 1'b0);
        wait_done(200, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
